load_store_unit: RTL and testbench

// - Initiator for the unified memory's data port. Converts core LB/LBU/LH/LHU/LW/SB/SH/SW requests

---
 rtl/load_store_unit_pkg.sv | 39 +++
 rtl/lsu_byte_lane.sv | 48 ++++
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 tb/tb_load_store_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit.
// Contents: address/data/enable typedefs, access size encoding, FSM state type,
// word-alignment mask and a misalignment helper.
package load_store_unit_pkg;

  localparam int unsigned ADDR_SHIFT = 2;  // byte address -> word index

  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;
  typedef logic        enable_t;

  // 2'b11 is not listed; consumers treat it as a word access.
  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    MERGE  = 2'b10,
    RESP   = 2'b11
  } lsu_state_t;

  localparam addr_t WORD_ALIGN_MASK = ~((32'd1 << ADDR_SHIFT) - 32'd1);

  // Halves need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] offset);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = offset[0];
      default: mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane steering for word-wide memories.
// Ports:
//   size        access size (00 byte, 01 half, else word)
//   is_unsigned zero-extend loads when set, sign-extend otherwise
//   lane        byte offset addr[1:0]; halves use lane[1]
//   word        full memory word
//   wdata       right-justified store data
//   load_data   extracted and extended load value
//   merge_data  word with the addressed lane replaced by wdata
module lsu_byte_lane
  import load_store_unit_pkg::*;
(
  input  logic [1:0] size,
  input  logic       is_unsigned,
  input  logic [1:0] lane,
  input  data_t      word,
  input  data_t      wdata,
  output data_t      load_data,
  output data_t      merge_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v     = '0;
    half_v     = '0;
    load_data  = word;
    merge_data = word;
    case (size)
      SIZE_B: begin
        byte_v                           = word[{lane, 3'b000} +: 8];
        load_data                        = {{24{~is_unsigned & byte_v[7]}}, byte_v};
        merge_data[{lane, 3'b000} +: 8]  = wdata[7:0];
      end
      SIZE_H: begin
        half_v                             = word[{lane[1], 4'b0000} +: 16];
        load_data                          = {{16{~is_unsigned & half_v[15]}}, half_v};
        merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = word;
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns core byte/half/word loads and stores into word-wide accesses on a
// memory port that reads combinationally, writes on clk and has no byte enables. Sub-word
// stores are performed as read-modify-write (ACCESS reads, MERGE writes).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_*             request handshake (accepted when req_valid_i && req_ready_o)
//   rsp_*             one-cycle completion pulse, load data, misalignment error
//   dmem_*            word-aligned memory port (ren/wen decoded from state)
// Configuration: define MISALIGN_TRAP_EN to answer misaligned halves/words with rsp_err_o
// straight from IDLE without touching memory; otherwise the low address bits just select lanes.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  addr_t       req_addr_i,
  input  data_t       req_wdata_i,
  output logic        rsp_valid_o,
  output data_t       rsp_rdata_o,
  output logic        rsp_err_o,
  output addr_t       dmem_addr_o,
  output logic        dmem_ren_o,
  input  data_t       dmem_rdata_i,
  output logic        dmem_wen_o,
  output data_t       dmem_wdata_o
);

  lsu_state_t  state_q, state_d;
  addr_t       addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        we_q, we_d;
  data_t       wdata_q, wdata_d;
  data_t       word_q, word_d;
  data_t       rdata_q, rdata_d;
  enable_t     ren, wen;
  logic        misalign;
  logic        sub_word;
  data_t       lane_word;
  data_t       load_data;
  data_t       merge_data;

`ifdef MISALIGN_TRAP_EN
  assign misalign = is_misaligned(req_size_i, req_addr_i[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign sub_word  = (size_q == SIZE_B) || (size_q == SIZE_H);
  // MERGE patches the word captured in ACCESS; otherwise steer live read data.
  assign lane_word = (state_q == MERGE) ? word_q : dmem_rdata_i;

  lsu_byte_lane u_byte_lane (
    .size        (size_q),
    .is_unsigned (uns_q),
    .lane        (addr_q[1:0]),
    .word        (lane_word),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    rdata_d      = rdata_q;
    ren          = 1'b0;
    wen          = 1'b0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          we_d    = req_we_i;
          wdata_d = req_wdata_i;
          if (misalign) begin
            rdata_d = '0;
            state_d = RESP;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        dmem_addr_o = addr_q & WORD_ALIGN_MASK;
        if (!we_q) begin
          ren     = 1'b1;
          rdata_d = load_data;
          state_d = RESP;
        end else if (sub_word) begin
          ren     = 1'b1;
          word_d  = dmem_rdata_i;
          state_d = MERGE;
        end else begin
          wen          = 1'b1;
          dmem_wdata_o = wdata_q;
          rdata_d      = '0;
          state_d      = RESP;
        end
      end
      MERGE: begin
        dmem_addr_o  = addr_q & WORD_ALIGN_MASK;
        wen          = 1'b1;
        dmem_wdata_o = merge_data;
        rdata_d      = '0;
        state_d      = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE && req_valid_i) begin
      err_q <= misalign;
    end
  end

  assign rsp_err_o = err_q && (state_q == RESP);
`else
  assign rsp_err_o = 1'b0;
`endif

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign dmem_ren_o  = ren;
  assign dmem_wen_o  = wen;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-wide memory model
// (combinational read, write on posedge). Word 0x40 starts as 0x8899AABB.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] dmem_addr;
  logic        dmem_ren;
  logic [31:0] dmem_rdata;
  logic        dmem_wen;
  logic [31:0] dmem_wdata;

  logic [31:0] mem [0:63];

  int total = 0;
  int bad   = 0;

  load_store_unit dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .dmem_addr_o    (dmem_addr),
    .dmem_ren_o     (dmem_ren),
    .dmem_rdata_i   (dmem_rdata),
    .dmem_wen_o     (dmem_wen),
    .dmem_wdata_o   (dmem_wdata)
  );

  always #5 clk = ~clk;

  assign dmem_rdata = mem[dmem_addr[7:2]];

  always @(posedge clk) begin
    if (dmem_wen) mem[dmem_addr[7:2]] <= dmem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Enables must never overlap.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      total++;
      assert (!(dmem_ren && dmem_wen))
      else begin
        bad++;
        $error("FAIL ren_wen_overlap: observed %b%b expected not 11", dmem_ren, dmem_wen);
      end
    end
  end

  // Presents one request; returns at the negedge of cycle T+1.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(negedge clk);
    req_valid    = 1'b0;
  endtask

  // Two-cycle load: ACCESS at T+1, response at T+2, idle after.
  task automatic load_chk(input string tag, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] exp);
    issue(1'b0, size, uns, addr, 32'd0);
    chk({tag, "_ren"}, {31'd0, dmem_ren}, 32'd1);
    chk({tag, "_addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
    chk({tag, "_early_rsp"}, {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_rsp"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_data"}, rsp_rdata, exp);
    chk({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    chk({tag, "_rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_hold"}, rsp_rdata, exp);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[16]      = 32'h8899_AABB;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;

    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_ren", {31'd0, dmem_ren}, 32'd0);
    chk("rst_wen", {31'd0, dmem_wen}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    rst = 1'b0;

    load_chk("lb_41", 2'b00, 1'b0, 32'h41, 32'hFFFF_FFAA);
    load_chk("lbu_43", 2'b00, 1'b1, 32'h43, 32'h0000_0088);
    load_chk("lhu_42", 2'b01, 1'b1, 32'h42, 32'h0000_8899);
    load_chk("lh_40", 2'b01, 1'b0, 32'h40, 32'hFFFF_AABB);
    load_chk("lb_40", 2'b00, 1'b0, 32'h40, 32'hFFFF_FFBB);

    // SH 0x42: read T+1, merged write T+2, response T+3.
    issue(1'b1, 2'b01, 1'b0, 32'h42, 32'h0000_1234);
    chk("sh_ren", {31'd0, dmem_ren}, 32'd1);
    chk("sh_wen_t1", {31'd0, dmem_wen}, 32'd0);
    @(negedge clk);
    chk("sh_wen", {31'd0, dmem_wen}, 32'd1);
    chk("sh_ren_t2", {31'd0, dmem_ren}, 32'd0);
    chk("sh_wdata", dmem_wdata, 32'h1234_AABB);
    chk("sh_addr", dmem_addr, 32'h40);
    chk("sh_rsp_t2", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("sh_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("sh_rdata", rsp_rdata, 32'd0);
    chk("sh_wen_t3", {31'd0, dmem_wen}, 32'd0);
    load_chk("lw_40_after_sh", 2'b10, 1'b0, 32'h40, 32'h1234_AABB);

    // SW 0x44: single write cycle at T+1, response T+2.
    issue(1'b1, 2'b10, 1'b0, 32'h44, 32'hDEAD_BEEF);
    chk("sw_wen", {31'd0, dmem_wen}, 32'd1);
    chk("sw_ren", {31'd0, dmem_ren}, 32'd0);
    chk("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
    chk("sw_addr", dmem_addr, 32'h44);
    @(negedge clk);
    chk("sw_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("sw_wen_t2", {31'd0, dmem_wen}, 32'd0);
    load_chk("lw_44", 2'b10, 1'b0, 32'h44, 32'hDEAD_BEEF);

    // SB 0x45 replaces lane 1 only.
    issue(1'b1, 2'b00, 1'b0, 32'h45, 32'hFFFF_FFA5);
    @(negedge clk);
    chk("sb_wdata", dmem_wdata, 32'hDEAD_A5EF);
    @(negedge clk);
    chk("sb_rsp", {31'd0, rsp_valid}, 32'd1);
    load_chk("lw_44_after_sb", 2'b10, 1'b0, 32'h44, 32'hDEAD_A5EF);

    // Size 2'b11 behaves as a word store; restores word 0x40.
    issue(1'b1, 2'b11, 1'b0, 32'h40, 32'h8899_AABB);
    chk("sz3_wen", {31'd0, dmem_wen}, 32'd1);
    @(negedge clk);
    chk("sz3_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("sz3_mem", mem[16], 32'h8899_AABB);

    // Reset in MERGE of SB 0x40: write must be dropped.
    issue(1'b1, 2'b00, 1'b0, 32'h40, 32'h0000_0055);
    chk("rmw_ren", {31'd0, dmem_ren}, 32'd1);
    @(negedge clk);
    chk("rmw_merge_wen", {31'd0, dmem_wen}, 32'd1);
    chk("rmw_merge_wdata", dmem_wdata, 32'h8899_AA55);
    rst = 1'b1;
    #1;
    chk("rmw_rst_wen", {31'd0, dmem_wen}, 32'd0);
    chk("rmw_rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rmw_rst_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    chk("rmw_rst_rsp_later", {31'd0, rsp_valid}, 32'd0);
    chk("rmw_mem_intact", mem[16], 32'h8899_AABB);
    rst = 1'b0;
    @(negedge clk);
    chk("rmw_no_rsp_after", {31'd0, rsp_valid}, 32'd0);

    // Misaligned LW 0x42.
`ifdef MISALIGN_TRAP_EN
    issue(1'b0, 2'b10, 1'b0, 32'h42, 32'd0);
    chk("mis_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("mis_err", {31'd0, rsp_err}, 32'd1);
    chk("mis_rdata", rsp_rdata, 32'd0);
    chk("mis_ren", {31'd0, dmem_ren}, 32'd0);
    chk("mis_wen", {31'd0, dmem_wen}, 32'd0);
    @(negedge clk);
    chk("mis_ready", {31'd0, req_ready}, 32'd1);
    chk("mis_err_drop", {31'd0, rsp_err}, 32'd0);
`else
    load_chk("mis_lw_42", 2'b10, 1'b0, 32'h42, 32'h8899_AABB);
`endif

    // Back-to-back: valid held high across two LW 0x44 transactions.
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h44;
    @(negedge clk);
    chk("b2b_t1_ready", {31'd0, req_ready}, 32'd0);
    chk("b2b_t1_ren", {31'd0, dmem_ren}, 32'd1);
    @(negedge clk);
    chk("b2b_t2_ready", {31'd0, req_ready}, 32'd0);
    chk("b2b_t2_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_t2_data", rsp_rdata, 32'hDEAD_A5EF);
    @(negedge clk);
    chk("b2b_t3_ready", {31'd0, req_ready}, 32'd1);
    chk("b2b_t3_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("b2b_t4_ready", {31'd0, req_ready}, 32'd0);
    chk("b2b_t4_ren", {31'd0, dmem_ren}, 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_t5_rsp", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    chk("b2b_t6_ready", {31'd0, req_ready}, 32'd1);
    chk("b2b_t6_rsp", {31'd0, rsp_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
